// File: rtl/alu_acc_if.sv
// Bundle of command, result and external-adder signals for alu_acc.
// Handshakes: a transfer occurs on a rising edge where valid && ready; the source holds its payload stable while valid && !ready.
interface alu_acc_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] operand_i;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] acc_o;
  logic [3:0]            flags_o;
  logic [CNT_WIDTH-1:0]  ops_o;

  logic [DATA_WIDTH-1:0] ai_o;
  logic [DATA_WIDTH-1:0] bi_o;
  logic                  cin_o;
  logic [DATA_WIDTH-1:0] result_i;
  logic                  cout_i;
  logic                  overflow_i;
  logic                  zero_i;

  modport slave (
    input  in_valid, op_i, operand_i, out_ready,
    input  result_i, cout_i, overflow_i, zero_i,
    output in_ready, out_valid, acc_o, flags_o, ops_o,
    output ai_o, bi_o, cin_o
  );

  modport master (
    output in_valid, op_i, operand_i, out_ready,
    output result_i, cout_i, overflow_i, zero_i,
    input  in_ready, out_valid, acc_o, flags_o, ops_o,
    input  ai_o, bi_o, cin_o
  );
endinterface

// File: rtl/alu_acc.sv
// Accumulator sequencer driving an external add/sub unit; one command in flight, result held until taken.
// Optional macro ALU_ACC_STICKY_V_EN makes the V flag sticky across add/sub/load.
module alu_acc #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_acc_if.slave    bus,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic [1:0]            state_q;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [3:0]            flags_q;
  logic [CNT_WIDTH-1:0]  ops_q;
  logic                  out_valid_q;

  logic                  in_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic [3:0]            flags_nxt;
  logic                  v_arith;
  logic                  v_load;

  // in_ready passes out_ready straight through in WAIT so a new command
  // can be taken on the same edge the pending result is consumed.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      WAIT:    in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

`ifdef ALU_ACC_STICKY_V_EN
  assign v_arith = flags_q[0] | bus.overflow_i;
  assign v_load  = flags_q[0];
`else
  assign v_arith = bus.overflow_i;
  assign v_load  = 1'b0;
`endif

  // flags are packed {N,Z,C,V}; C from the adder is passed through raw,
  // so after a subtract C=1 means no borrow.
  always_comb begin
    acc_nxt   = acc_q;
    flags_nxt = flags_q;
    case (op_q)
      OP_ADD, OP_SUB: begin
        acc_nxt   = bus.result_i;
        flags_nxt = {bus.result_i[DATA_WIDTH-1], bus.zero_i, bus.cout_i, v_arith};
      end
      OP_LOAD: begin
        acc_nxt   = opnd_q;
        flags_nxt = {opnd_q[DATA_WIDTH-1], (opnd_q == '0), 1'b0, v_load};
      end
      OP_CLR: begin
        acc_nxt   = '0;
        flags_nxt = 4'b0100;
      end
      default: begin
        acc_nxt   = acc_q;
        flags_nxt = flags_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      opnd_q      <= '0;
      acc_q       <= '0;
      flags_q     <= 4'b0000;
      ops_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.op_i;
        opnd_q <= bus.operand_i;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          acc_q       <= acc_nxt;
          flags_q     <= flags_nxt;
          ops_q       <= ops_q + CNT_WIDTH'(1);
          out_valid_q <= 1'b1;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_o     = acc_q;
  assign bus.flags_o   = flags_q;
  assign bus.ops_o     = ops_q;

  // Adder operands come straight from registers, so bi_o/cin_o naturally
  // hold the last latched command outside EXEC.
  assign bus.ai_o  = acc_q;
  assign bus.bi_o  = opnd_q;
  assign bus.cin_o = (op_q == OP_SUB);

  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_acc.sv
// Bench for alu_acc (DATA_WIDTH=4) with a behavioural add/sub unit and an arithmetic reference model.
// Define ALU_ACC_STICKY_V_EN for both bench and RTL to check the sticky-V build.
module tb_alu_acc;
  localparam int DW = 4;
  localparam int CW = 8;
  localparam int EW = DW + 4 + CW;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;
  localparam logic [1:0] CLR  = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  alu_acc_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  alu_acc #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- external adder ----------------
  logic [DW-1:0] b_eff;
  logic [DW:0]   sum;
  always_comb begin
    b_eff = bus.cin_o ? ~bus.bi_o : bus.bi_o;
    sum   = {1'b0, bus.ai_o} + {1'b0, b_eff} + {{DW{1'b0}}, bus.cin_o};
  end
  assign bus.result_i   = sum[DW-1:0];
  assign bus.cout_i     = sum[DW];
  assign bus.overflow_i = (bus.ai_o[DW-1] == b_eff[DW-1]) && (sum[DW-1] != bus.ai_o[DW-1]);
  assign bus.zero_i     = (sum[DW-1:0] == '0);

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_acc;
  logic m_n, m_z, m_c, m_v;
  int   m_ops;
  int   acc_cyc = 0;
  logic [EW-1:0] exp_q[$];

  task automatic model_reset();
    m_acc = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_ops = 0;
    exp_q.delete();
  endtask

  function automatic int to_signed(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  task automatic model_accept(input logic [1:0] op, input logic [3:0] val);
    int a, b, s;
    logic ov;
    a = m_acc;
    b = int'(val);
    ov = 1'b0;
    case (op)
      LOAD: begin
        m_acc = b;
        m_c = 1'b0;
`ifndef ALU_ACC_STICKY_V_EN
        m_v = 1'b0;
`endif
      end
      ADD: begin
        m_c   = (a + b) >= 16;
        m_acc = (a + b) % 16;
        s  = to_signed(a) + to_signed(b);
        ov = (s > 7) || (s < -8);
`ifdef ALU_ACC_STICKY_V_EN
        m_v = m_v | ov;
`else
        m_v = ov;
`endif
      end
      SUB: begin
        m_c   = (a >= b);
        m_acc = (a - b + 16) % 16;
        s  = to_signed(a) - to_signed(b);
        ov = (s > 7) || (s < -8);
`ifdef ALU_ACC_STICKY_V_EN
        m_v = m_v | ov;
`else
        m_v = ov;
`endif
      end
      default: begin
        m_acc = 0; m_c = 1'b0; m_v = 1'b0;
      end
    endcase
    m_n   = (m_acc >= 8);
    m_z   = (m_acc == 0);
    m_ops = (m_ops + 1) % 256;
    exp_q.push_back({4'(m_acc), m_n, m_z, m_c, m_v, 8'(m_ops)});
  endtask

  // One compare process: every result handed over is checked against the model,
  // and each rise of out_valid is checked for its distance from the accept edge.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov)
        check("latency", 32'(cyc - acc_cyc), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("acc_o",   32'(bus.acc_o),   32'(e[EW-1 -: DW]));
          check("flags_o", 32'(bus.flags_o), 32'(e[CW+3 -: 4]));
          check("ops_o",   32'(bus.ops_o),   32'(e[CW-1:0]));
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [3:0] val);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.op_i      = op;
    bus.operand_i = val;
    @(negedge clk);
    while (!bus.in_ready) begin
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    model_accept(op, val);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid) begin
      n++;
      if (n > 20) begin
        check("result_timeout", 32'(bus.out_valid), 32'd1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_out_ready(input logic v);
    @(posedge clk); #1;
    bus.out_ready = v;
  endtask

  logic [1:0] t_op  [10] = '{LOAD, ADD, SUB, SUB, ADD, LOAD, SUB, CLR, ADD, SUB};
  logic [3:0] t_val [10] = '{4'd5, 4'd6, 4'd2, 4'd15, 4'd9, 4'd8, 4'd1, 4'd0, 4'd0, 4'd1};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_i      = LOAD;
    bus.operand_i = '0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_acc",       32'(bus.acc_o),     32'd0);
    check("rst_flags",     32'(bus.flags_o),   32'd0);
    check("rst_ops",       32'(bus.ops_o),     32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);

    // load 7, add 1
    send(LOAD, 4'd7);
    send(ADD, 4'd1);
    wait_result();
    check("l7a1_acc",   32'(bus.acc_o),   32'd8);
    check("l7a1_flags", 32'(bus.flags_o), 32'b1001);
    check("l7a1_ops",   32'(bus.ops_o),   32'd2);

    // load 3, sub 3
    send(CLR, 4'd0);
    send(LOAD, 4'd3);
    send(SUB, 4'd3);
    @(negedge clk);
    check("sub_cin_exec", 32'(bus.cin_o), 32'd1);
    check("sub_ai_exec",  32'(bus.ai_o),  32'd3);
    check("sub_bi_exec",  32'(bus.bi_o),  32'd3);
    wait_result();
    check("l3s3_acc",   32'(bus.acc_o),   32'd0);
    check("l3s3_flags", 32'(bus.flags_o), 32'b0110);
    repeat (2) @(negedge clk);
    check("bi_hold_idle",  32'(bus.bi_o),  32'd3);
    check("cin_hold_idle", 32'(bus.cin_o), 32'd1);

    // back-pressure: result held while the next command waits
    set_out_ready(1'b0);
    send(LOAD, 4'd5);
    fork
      send(ADD, 4'd2);
      begin
        @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          check("hold_out_valid", 32'(bus.out_valid), 32'd1);
          check("hold_in_ready",  32'(bus.in_ready),  32'd0);
          check("hold_acc",       32'(bus.acc_o),     32'd5);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_result();
    check("hold_next_acc", 32'(bus.acc_o), 32'd7);

    // overflow then add 0, then clear
    send(LOAD, 4'd7);
    send(ADD, 4'd1);
    send(ADD, 4'd0);
    wait_result();
`ifdef ALU_ACC_STICKY_V_EN
    check("v_after_add0", 32'(bus.flags_o[0]), 32'd1);
`else
    check("v_after_add0", 32'(bus.flags_o[0]), 32'd0);
`endif
    send(CLR, 4'd0);
    wait_result();
    check("clr_flags", 32'(bus.flags_o), 32'b0100);
    check("clr_acc",   32'(bus.acc_o),   32'd0);

    // directed table, checked by the model
    for (int i = 0; i < 10; i++) send(t_op[i], t_val[i]);
    wait_result();

    // reset during EXEC
    send(LOAD, 4'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("rst_exec_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_exec_acc",       32'(bus.acc_o),     32'd0);
      check("rst_exec_ops",       32'(bus.ops_o),     32'd0);
    end

    // reset wins over a command offered on the same edge
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op_i      = LOAD;
    bus.operand_i = 4'd5;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_accept_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_accept_acc",       32'(bus.acc_o),     32'd0);
    end

    // 256 clears wrap the op counter
    for (int i = 0; i < 256; i++) send(CLR, 4'd0);
    wait_result();
    check("ops_wrap", 32'(bus.ops_o), 32'd0);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
